// File: rtl/tx_control_pkg.sv
// Shared system-control definitions: the transmit FSM state encoding and the
// default datapath byte width, also used by the Rx-side control.
package tx_control_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_RD     = 2'd1,
    SEND_ALU_LO = 2'd2,
    SEND_ALU_HI = 2'd3
  } state_t;

endpackage

// File: rtl/tx_control_if.sv
// Bundle of result strobes from the register file / ALU, the UART transmit
// handshake, and the status flags of tx_control.
interface tx_control_if
  import tx_control_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) ();

  logic [width-1:0]   RdData;
  logic               RdValid;
  logic [2*width-1:0] ALU_OUT;
  logic               ALU_Valid;
  logic               Tx_Ready;
  logic [width-1:0]   Tx_P_Data;
  logic               Tx_Valid;
  logic               Busy;
  logic               Drop;

  // Producer side: sources the strobes and the transmitter ready.
  modport master (
    output RdData, RdValid, ALU_OUT, ALU_Valid, Tx_Ready,
    input  Tx_P_Data, Tx_Valid, Busy, Drop
  );

  // tx_control side.
  modport slave (
    input  RdData, RdValid, ALU_OUT, ALU_Valid, Tx_Ready,
    output Tx_P_Data, Tx_Valid, Busy, Drop
  );

endinterface

// File: rtl/tx_control.sv
// Serialises register reads (one byte) and ALU results (low byte, then high
// byte) onto a valid/ready UART transmit port; strobes arriving while busy are dropped.
module tx_control
  import tx_control_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic         CLK,
  input  logic         Reset,
  tx_control_if.slave  bus
);

  state_t             state, state_nxt;
  logic [2*width-1:0] alu_latch, alu_latch_nxt;
  logic               alu_pending, alu_pending_nxt;
  logic [width-1:0]   tx_data, tx_data_nxt;
  logic               tx_vld, tx_vld_nxt;
  logic               drop, drop_nxt;
  logic               xfer;

  assign xfer = tx_vld & bus.Tx_Ready;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      alu_latch   <= '0;
      alu_pending <= 1'b0;
      tx_data     <= '0;
      tx_vld      <= 1'b0;
      drop        <= 1'b0;
    end else begin
      state       <= state_nxt;
      alu_latch   <= alu_latch_nxt;
      alu_pending <= alu_pending_nxt;
      tx_data     <= tx_data_nxt;
      tx_vld      <= tx_vld_nxt;
      drop        <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    alu_latch_nxt   = alu_latch;
    alu_pending_nxt = alu_pending;
    tx_data_nxt     = tx_data;
    tx_vld_nxt      = tx_vld;
    // Both strobes together still yield a single one-cycle Drop pulse.
    drop_nxt        = (state != IDLE) && (bus.RdValid || bus.ALU_Valid);

    unique case (state)
      IDLE: begin
        if (bus.RdValid) begin
          tx_data_nxt = bus.RdData;
          tx_vld_nxt  = 1'b1;
          state_nxt   = SEND_RD;
          // A simultaneous ALU result is parked and sent after the read byte.
          if (bus.ALU_Valid) begin
            alu_latch_nxt   = bus.ALU_OUT;
            alu_pending_nxt = 1'b1;
          end
        end else if (bus.ALU_Valid) begin
          alu_latch_nxt = bus.ALU_OUT;
          tx_data_nxt   = bus.ALU_OUT[width-1:0];
          tx_vld_nxt    = 1'b1;
          state_nxt     = SEND_ALU_LO;
        end
      end
      SEND_RD: begin
        if (xfer) begin
          if (alu_pending) begin
            tx_data_nxt     = alu_latch[width-1:0];
            alu_pending_nxt = 1'b0;
            state_nxt       = SEND_ALU_LO;
          end else begin
            tx_vld_nxt = 1'b0;
            state_nxt  = IDLE;
          end
        end
      end
      SEND_ALU_LO: begin
        if (xfer) begin
          tx_data_nxt = alu_latch[2*width-1:width];
          state_nxt   = SEND_ALU_HI;
        end
      end
      SEND_ALU_HI: begin
        if (xfer) begin
          tx_vld_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.Tx_P_Data = tx_data;
  assign bus.Tx_Valid  = tx_vld;
  assign bus.Drop      = drop;
  assign bus.Busy      = (state != IDLE);

endmodule

// File: tb/tb_tx_control.sv
// Directed and randomized checks of tx_control against a byte-queue reference:
// accepted strobes enqueue bytes, the head is offered, a ready edge pops it.
module tb_tx_control;

  logic CLK;
  logic Reset;
  int   checks = 0;
  int   fails  = 0;

  // Reference: bytes still to be transmitted; head is the byte on offer.
  logic [7:0] q[$];

  tx_control_if #(.width(8)) bus ();

  tx_control #(.width(8)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the reference across the edge, then check.
  task automatic cycle(input logic rd, input logic [7:0] rdd, input logic alu,
                       input logic [15:0] aluo, input logic rdy, input string tag);
    logic busy_pre;
    logic m_drop;
    bus.RdValid   = rd;
    bus.RdData    = rdd;
    bus.ALU_Valid = alu;
    bus.ALU_OUT   = aluo;
    bus.Tx_Ready  = rdy;
    @(posedge CLK);
    busy_pre = (q.size() != 0);
    m_drop   = busy_pre && (rd || alu);
    if (busy_pre) begin
      if (rdy) void'(q.pop_front());
    end else begin
      if (rd) q.push_back(rdd);
      if (alu) begin
        q.push_back(aluo[7:0]);
        q.push_back(aluo[15:8]);
      end
    end
    #1;
    check({tag, "/valid"}, 8'(bus.Tx_Valid), 8'(q.size() != 0));
    check({tag, "/busy"},  8'(bus.Busy),     8'(q.size() != 0));
    check({tag, "/drop"},  8'(bus.Drop),     8'(m_drop));
    if (q.size() != 0) check({tag, "/data"}, bus.Tx_P_Data, q[0]);
  endtask

  task automatic idle_cycle(input logic rdy, input string tag);
    cycle(1'b0, 8'h00, 1'b0, 16'h0000, rdy, tag);
  endtask

  initial begin
    Reset         = 1'b0;
    bus.RdValid   = 1'b0;
    bus.RdData    = '0;
    bus.ALU_Valid = 1'b0;
    bus.ALU_OUT   = '0;
    bus.Tx_Ready  = 1'b0;
    #1 Reset = 1'b1;
    #1;
    check("reset/valid", 8'(bus.Tx_Valid), 8'h00);
    check("reset/busy",  8'(bus.Busy),     8'h00);
    check("reset/drop",  8'(bus.Drop),     8'h00);
    check("reset/data",  bus.Tx_P_Data,    8'h00);
    @(posedge CLK);
    @(posedge CLK);
    #2 Reset = 1'b0;

    // Single read byte with ready held high.
    cycle(1'b1, 8'hA5, 1'b0, 16'h0000, 1'b1, "rd_a5");
    check("rd_a5/byte", bus.Tx_P_Data, 8'hA5);
    idle_cycle(1'b1, "rd_a5_done");
    check("rd_a5_done/busy", 8'(bus.Busy), 8'h00);

    // ALU result: low byte then high byte on consecutive cycles.
    cycle(1'b0, 8'h00, 1'b1, 16'h1234, 1'b1, "alu_lo");
    check("alu_lo/byte", bus.Tx_P_Data, 8'h34);
    idle_cycle(1'b1, "alu_hi");
    check("alu_hi/byte", bus.Tx_P_Data, 8'h12);
    idle_cycle(1'b1, "alu_done");
    check("alu_done/valid", 8'(bus.Tx_Valid), 8'h00);

    // Simultaneous read and ALU strobes: read byte first, nothing dropped.
    cycle(1'b1, 8'h5A, 1'b1, 16'hBEEF, 1'b1, "both_rd");
    check("both_rd/byte", bus.Tx_P_Data, 8'h5A);
    idle_cycle(1'b1, "both_lo");
    check("both_lo/byte", bus.Tx_P_Data, 8'hEF);
    idle_cycle(1'b1, "both_hi");
    check("both_hi/byte", bus.Tx_P_Data, 8'hBE);
    idle_cycle(1'b1, "both_done");

    // Five-cycle stall on the low byte.
    cycle(1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, "stall_lo");
    for (int i = 0; i < 5; i++) begin
      idle_cycle(1'b0, "stall_hold");
      check("stall_hold/byte", bus.Tx_P_Data, 8'h34);
    end
    idle_cycle(1'b1, "stall_hi");
    check("stall_hi/byte", bus.Tx_P_Data, 8'h12);
    idle_cycle(1'b1, "stall_done");

    // Stray read strobe on the final transfer, then both strobes while busy.
    cycle(1'b0, 8'h00, 1'b1, 16'h1234, 1'b1, "drop_lo");
    idle_cycle(1'b1, "drop_hi");
    cycle(1'b1, 8'h77, 1'b0, 16'h0000, 1'b1, "drop_rd");
    check("drop_rd/pulse", 8'(bus.Drop), 8'h01);
    idle_cycle(1'b1, "drop_clear");
    check("drop_clear/pulse", 8'(bus.Drop), 8'h00);
    cycle(1'b1, 8'h11, 1'b0, 16'h0000, 1'b0, "busy_rd");
    cycle(1'b1, 8'h99, 1'b1, 16'hCAFE, 1'b1, "drop_both");
    check("drop_both/pulse", 8'(bus.Drop), 8'h01);
    idle_cycle(1'b1, "drop_both_clear");
    check("drop_both_clear/pulse", 8'(bus.Drop), 8'h00);

    // Asynchronous reset while stalled on the ALU low byte.
    cycle(1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, "abort_lo");
    idle_cycle(1'b0, "abort_hold");
    #2 Reset = 1'b1;
    #1;
    check("abort/valid", 8'(bus.Tx_Valid), 8'h00);
    check("abort/busy",  8'(bus.Busy),     8'h00);
    check("abort/data",  bus.Tx_P_Data,    8'h00);
    q.delete();
    @(posedge CLK);
    #2 Reset = 1'b0;
    cycle(1'b1, 8'h01, 1'b0, 16'h0000, 1'b1, "post_rd");
    check("post_rd/byte", bus.Tx_P_Data, 8'h01);
    idle_cycle(1'b1, "post_done");
    check("post_done/valid", 8'(bus.Tx_Valid), 8'h00);
    idle_cycle(1'b1, "post_quiet");

    // Randomized traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 3) == 0),
            16'($urandom), 1'($urandom_range(0, 9) < 7), "rand");
    end
    for (int i = 0; i < 4; i++) idle_cycle(1'b1, "drain");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/tx_control.md
TX_CONTROL -- requirements
Module: tx_control

Interface
REQ-001 SHALL have parameter: width, default 8, byte width of all data paths.
REQ-002 SHALL have port: CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port: Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: RdData  input  width  register-file read data.
REQ-005 SHALL have port: RdValid  input  1  one-cycle strobe; RdData valid this cycle.
REQ-006 SHALL have port: ALU_OUT  input  2*width  ALU result.
REQ-007 SHALL have port: ALU_Valid  input  1  one-cycle strobe; ALU_OUT valid this cycle.
REQ-008 SHALL have port: Tx_Ready  input  1  UART transmitter can accept a byte.
REQ-009 SHALL have port: Tx_P_Data  output  width  byte offered to the UART transmitter.
REQ-010 SHALL have port: Tx_Valid  output  1  Tx_P_Data is valid; a byte transfers on any rising edge where Tx_Valid and Tx_Ready are both 1.
REQ-011 SHALL have port: Busy  output  1  high whenever the state is not IDLE.
REQ-012 SHALL have port: Drop  output  1  one-cycle pulse when an input strobe is discarded.

Function
REQ-013 SHALL implement the states IDLE, SEND_RD, SEND_ALU_LO and SEND_ALU_HI.
REQ-014 SHALL register Tx_P_Data, Tx_Valid and Drop; Busy SHALL decode the state register only, with no input-to-output combinational path.
REQ-015 IDLE with RdValid=1 at edge n SHALL, from edge n, drive Tx_P_Data=RdData and Tx_Valid=1, and enter SEND_RD.
REQ-016 IDLE with ALU_Valid=1 and RdValid=0 at edge n SHALL latch ALU_OUT, drive Tx_P_Data=ALU_OUT[width-1:0] and Tx_Valid=1, and enter SEND_ALU_LO.
REQ-017 IDLE with RdValid=1 and ALU_Valid=1 in the same cycle SHALL also latch ALU_OUT and set alu_pending; the RdData byte is sent first and neither strobe is dropped.
REQ-018 While Tx_Valid=1 and Tx_Ready=0, Tx_P_Data and Tx_Valid SHALL hold unchanged; there is no timeout.
REQ-019 SEND_RD on transfer SHALL do the following:
  - with alu_pending=1: load the latched low byte, clear alu_pending, keep Tx_Valid=1 and go to SEND_ALU_LO;
  - otherwise: drive Tx_Valid=0 and go to IDLE.
REQ-020 SEND_ALU_LO on transfer SHALL load the latched high byte ALU_OUT[2*width-1:width], keep Tx_Valid=1 and go to SEND_ALU_HI.
REQ-021 SEND_ALU_HI on transfer SHALL drive Tx_Valid=0 and go to IDLE.
REQ-022 Byte order SHALL be fixed: ALU result low byte first, then high byte.
REQ-023 Any RdValid or ALU_Valid sampled in a state other than IDLE SHALL be ignored and SHALL set Drop=1 for exactly the next cycle; this includes a strobe in the same cycle as the final transfer.
REQ-024 When RdValid and ALU_Valid are both sampled outside IDLE, the block SHALL raise a single Drop pulse.
REQ-025 With Tx_Ready held at 1, transmission SHALL occupy 1 cycle per byte:
  - a read occupies 1 cycle, and IDLE is re-entered at edge n+1;
  - an ALU result occupies 2 consecutive cycles.

Reset
REQ-026 Reset=1 SHALL asynchronously force the following:
  - state=IDLE;
  - Tx_Valid=0, Tx_P_Data=0, Drop=0, Busy=0;
  - alu_pending=0 and the ALU latch = 0.
REQ-027 Reset asserted mid-transfer SHALL abort the frame; after release, no partial byte is resent.
REQ-028 Reset release SHALL take effect at the first rising CLK edge after deassertion, with no extra wait cycles.

Structure
REQ-029 The state encoding (2-bit, IDLE=0) and the default width constant SHALL reside in the shared system-control package used by the Rx control.
REQ-030 The block SHALL be a single module with no sub-modules; the byte-select mux and the ALU latch SHALL be inline.

Verification
REQ-031 Bench: Reset, then RdValid with RdData=0xA5 and Tx_Ready=1 -> Tx_Valid high for 1 cycle with 0xA5, Busy for 1 cycle, Drop=0.
REQ-032 Bench: ALU_Valid with ALU_OUT=0x1234 and Tx_Ready=1 -> bytes 0x34 then 0x12 on consecutive cycles, then IDLE.
REQ-033 Bench: RdValid=1 with RdData=0x5A and ALU_Valid=1 with ALU_OUT=0xBEEF in the same cycle -> bytes 0x5A, 0xEF, 0xBE in order, Drop=0.
REQ-034 Bench: Tx_Ready=0 for 5 cycles during SEND_ALU_LO -> 0x34 held stable with Tx_Valid=1 for the whole stall; 0x12 follows when Tx_Ready=1.
REQ-035 Bench: RdValid during SEND_ALU_HI -> one Drop pulse; the stray byte never appears on Tx_P_Data.
REQ-036 Bench: Reset asserted mid-cycle while in SEND_ALU_LO with Tx_Ready=0 -> Tx_Valid and Busy fall immediately (asynchronously); the next RdValid with RdData=0x01 sends only 0x01.
